// File: rtl/matrix_frame_sequencer.sv
// matrix_frame_sequencer
// Streams one LED-matrix frame from a synchronous-read frame buffer into a
// multi-lane SPI transmitter, one word at a time, then holds a latch gap and
// hands the buffer back upstream.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   enable            frame starts allowed (looked at only while idle)
//   frame_valid       upstream buffer holds a complete frame
//   frame_done        one-cycle pulse once the frame is out and the gap elapsed
//   busy              high whenever a frame is in progress
//   error             sticky: transmitter never went busy after a start
//   rd_en, rd_addr    buffer read strobe / address (data returns next cycle)
//   rd_data           buffer read data, lane i at [i*SPI_SIZE +: SPI_SIZE]
//   tx_data           word presented to the transmitter, same lane packing
//   tx_start          one-cycle start pulse to the transmitter
//   tx_idle           transmitter idle indication
module matrix_frame_sequencer #(
    parameter int CHANNEL_NUMBER  = 3,
    parameter int SPI_SIZE        = 8,
    parameter int BYTES_PER_FRAME = 384,
    parameter int ADDR_WIDTH      = $clog2(BYTES_PER_FRAME),
    parameter int GAP_CYCLES      = 64,
    parameter int BUSY_TIMEOUT    = 15
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic                               frame_valid,
    output logic                               frame_done,
    output logic                               busy,
    output logic                               error,
    output logic                               rd_en,
    output logic [ADDR_WIDTH-1:0]              rd_addr,
    input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] rd_data,
    output logic [CHANNEL_NUMBER*SPI_SIZE-1:0] tx_data,
    output logic                               tx_start,
    input  logic                               tx_idle
);

    localparam int DW      = CHANNEL_NUMBER * SPI_SIZE;
    // One counter serves both the busy timeout and the latch gap.
    localparam int CNT_MAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(BYTES_PER_FRAME - 1);
    localparam logic [CW-1:0]         BUSY_LAST = CW'(BUSY_TIMEOUT - 1);
    localparam logic [CW-1:0]         GAP_LAST  = CW'(GAP_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_WAIT_DATA = 3'd2;
    localparam logic [2:0] S_START     = 3'd3;
    localparam logic [2:0] S_WAIT_BUSY = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;
    localparam logic [2:0] S_GAP       = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]         tx_data_q, tx_data_d;
    logic                  error_q, error_d;

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        error_d   = error_q;
        case (state_q)
            S_IDLE: begin
                if (enable && frame_valid && !error_q) begin
                    state_d = S_FETCH;
                    index_d = '0;
                end
            end
            S_FETCH:     state_d = S_WAIT_DATA;
            S_WAIT_DATA: begin
                // Latched once per word so the transmitter sees a stable word
                // no matter what the buffer port does afterwards.
                tx_data_d = rd_data;
                state_d   = S_START;
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // A word only completes on idle going low then high again;
                // an idle level seen at start is not taken as completion.
                if (!tx_idle) begin
                    state_d = S_WAIT_IDLE;
                end else if (cnt_q == BUSY_LAST) begin
                    error_d = 1'b1;
                    index_d = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (tx_idle) begin
                    if (index_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        index_d = index_q + ADDR_WIDTH'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) state_d = S_DONE;
                else                   cnt_d   = cnt_q + CW'(1);
            end
            S_DONE: begin
                index_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            index_q   <= '0;
            cnt_q     <= '0;
            tx_data_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            error_q   <= error_d;
        end
    end

    // Outputs decode straight from registered state so reset clears them at once.
    assign rd_en      = (state_q == S_FETCH);
    assign rd_addr    = index_q;
    assign tx_start   = (state_q == S_START);
    assign frame_done = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign tx_data    = tx_data_q;
    assign error      = error_q;

endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// Directed bench for matrix_frame_sequencer: 4-word frames, 3-cycle gap,
// busy timeout of 5, transmitter model busy 18 cycles starting 2 after start.
module tb_matrix_frame_sequencer;

    localparam int AW = 2;
    localparam int DW = 24;

    logic          clk = 1'b0, rst = 1'b1, enable = 1'b0, frame_valid = 1'b0;
    logic          frame_done, busy, error, rd_en, tx_start, tx_idle;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0, tx_data;

    int   cyc = 0, tcnt = 0;
    logic stuck = 1'b0, noise = 1'b0;
    logic [DW-1:0] mem [4] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};

    int n_pass = 0, n_total = 0;

    matrix_frame_sequencer #(
        .CHANNEL_NUMBER(3), .SPI_SIZE(8), .BYTES_PER_FRAME(4), .ADDR_WIDTH(AW),
        .GAP_CYCLES(3), .BUSY_TIMEOUT(5)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_valid(frame_valid),
        .frame_done(frame_done), .busy(busy), .error(error),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_data(tx_data), .tx_start(tx_start), .tx_idle(tx_idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer: synchronous read, or a value that changes every cycle.
    always @(posedge clk) begin
        if (noise)      rd_data <= DW'(cyc * 7 + 3);
        else if (rd_en) rd_data <= mem[rd_addr];
    end

    // Transmitter: busy for tcnt 2..19 (18 cycles) after a start.
    always @(posedge clk) begin
        if (tx_start)         tcnt <= 1;
        else if (tcnt == 19)  tcnt <= 0;
        else if (tcnt != 0)   tcnt <= tcnt + 1;
    end
    assign tx_idle = stuck || (tcnt < 2);

    // Event monitor (sampled on the falling edge).
    logic [7:0]    rd_n = '0, st_n = '0, dn_n = '0, er_n = '0;
    logic [7:0]    rd_b = '0, st_b = '0, dn_b = '0, er_b = '0;
    logic [AW-1:0] rd_a [256];
    int            rd_cy [256], st_cy [256], dn_cy [256], er_cy [256];
    logic [DW-1:0] st_d [256];
    logic [DW-1:0] txd_log [4096], rdd_log [4096];
    logic          err_prev = 1'b0;

    always @(negedge clk) begin
        if (rd_en)      begin rd_a[rd_n] <= rd_addr; rd_cy[rd_n] <= cyc; rd_n <= rd_n + 8'd1; end
        if (tx_start)   begin st_d[st_n] <= tx_data; st_cy[st_n] <= cyc; st_n <= st_n + 8'd1; end
        if (frame_done) begin dn_cy[dn_n] <= cyc; dn_n <= dn_n + 8'd1; end
        if (error && !err_prev) begin er_cy[er_n] <= cyc; er_n <= er_n + 8'd1; end
        err_prev <= error;
        txd_log[cyc[11:0]] <= tx_data;
        rdd_log[cyc[11:0]] <= rd_data;
    end

    function automatic int nrd(); return int'(8'(rd_n - rd_b)); endfunction
    function automatic int nst(); return int'(8'(st_n - st_b)); endfunction
    function automatic int ndn(); return int'(8'(dn_n - dn_b)); endfunction
    function automatic int ner(); return int'(8'(er_n - er_b)); endfunction
    function automatic int            rdc(int i); return rd_cy[8'(rd_b + 8'(i))]; endfunction
    function automatic logic [AW-1:0] rda(int i); return rd_a[8'(rd_b + 8'(i))];  endfunction
    function automatic int            stc(int i); return st_cy[8'(st_b + 8'(i))]; endfunction
    function automatic logic [DW-1:0] std(int i); return st_d[8'(st_b + 8'(i))];  endfunction
    function automatic int            dnc(int i); return dn_cy[8'(dn_b + 8'(i))]; endfunction
    function automatic int            erc(int i); return er_cy[8'(er_b + 8'(i))]; endfunction

    task automatic clear_log();
        rd_b = rd_n; st_b = st_n; dn_b = dn_n; er_b = er_n;
    endtask

    task automatic tick(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        tick(3);
        n_total++; if ({frame_done, busy, error, rd_en, tx_start} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {frame_done, busy, error, rd_en, tx_start}); else n_pass++;
        n_total++; if (rd_addr !== 2'd0) $display("FAIL reset_addr: got %0h want 0", rd_addr); else n_pass++;
        n_total++; if (tx_data !== 24'h0) $display("FAIL reset_txdata: got %0h want 0", tx_data); else n_pass++;
        rst = 1'b0;
        tick(3);
        n_total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_basic();
        int t;
        clear_log();
        enable = 1'b1; frame_valid = 1'b1;
        t = 0; while (nrd() < 1 && t < 20) begin tick(1); t++; end
        frame_valid = 1'b0;
        t = 0; while (ndn() < 1 && t < 600) begin tick(1); t++; end
        tick(5);
        n_total++; if (nrd() != 4) $display("FAIL basic_rd_count: got %0d want 4", nrd()); else n_pass++;
        n_total++; if (nst() != 4) $display("FAIL basic_start_count: got %0d want 4", nst()); else n_pass++;
        n_total++; if (ndn() != 1) $display("FAIL basic_done_count: got %0d want 1", ndn()); else n_pass++;
        if (nrd() == 4 && nst() == 4 && ndn() == 1) begin
            for (int i = 0; i < 4; i++) begin
                n_total++; if (rda(i) !== AW'(i)) $display("FAIL basic_addr%0d: got %0d want %0d", i, rda(i), i); else n_pass++;
                n_total++; if (stc(i) - rdc(i) != 2) $display("FAIL basic_rd2start%0d: got %0d want 2", i, stc(i) - rdc(i)); else n_pass++;
                n_total++; if (std(i) !== mem[i]) $display("FAIL basic_txdata%0d: got %0h want %0h", i, std(i), mem[i]); else n_pass++;
            end
            for (int i = 0; i < 3; i++) begin
                n_total++; if (rdc(i + 1) - rdc(i) != 23) $display("FAIL basic_period%0d: got %0d want 23", i, rdc(i + 1) - rdc(i)); else n_pass++;
            end
            // last FETCH f: START f+2, busy f+4..f+21, idle seen f+22, done f+26
            n_total++; if (dnc(0) - rdc(3) != 26) $display("FAIL basic_done_time: got %0d want 26", dnc(0) - rdc(3)); else n_pass++;
        end
        n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_enable_gate();
        int t;
        clear_log();
        enable = 1'b0; frame_valid = 1'b1;
        tick(100);
        n_total++; if (nrd() != 0) $display("FAIL gate_rd: got %0d want 0", nrd()); else n_pass++;
        n_total++; if (nst() != 0) $display("FAIL gate_start: got %0d want 0", nst()); else n_pass++;
        enable = 1'b1;
        t = 0; while (nrd() < 1 && t < 20) begin tick(1); t++; end
        frame_valid = 1'b0;
        tick(10);
        enable = 1'b0;
        t = 0; while (ndn() < 1 && t < 600) begin tick(1); t++; end
        tick(5);
        n_total++; if (ndn() != 1) $display("FAIL gate_midframe_done: got %0d want 1", ndn()); else n_pass++;
        n_total++; if (nst() != 4) $display("FAIL gate_midframe_starts: got %0d want 4", nst()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int t;
        clear_log();
        enable = 1'b1; frame_valid = 1'b1;
        t = 0; while (ndn() < 2 && t < 1200) begin tick(1); t++; end
        frame_valid = 1'b0;
        tick(5);
        n_total++; if (nst() != 8) $display("FAIL b2b_starts: got %0d want 8", nst()); else n_pass++;
        n_total++; if (ndn() != 2) $display("FAIL b2b_dones: got %0d want 2", ndn()); else n_pass++;
        if (nrd() == 8 && ndn() == 2) begin
            n_total++; if (rdc(4) - dnc(0) != 2) $display("FAIL b2b_gap: got %0d want 2", rdc(4) - dnc(0)); else n_pass++;
            n_total++; if (rda(4) !== 2'd0) $display("FAIL b2b_restart_addr: got %0d want 0", rda(4)); else n_pass++;
        end else begin
            n_total++; $display("FAIL b2b_rd_count: got %0d want 8", nrd());
        end
        enable = 1'b0;
    endtask

    task automatic test_stable_data();
        int t, bad, last;
        logic [DW-1:0] exp;
        clear_log();
        noise = 1'b1; enable = 1'b1; frame_valid = 1'b1;
        t = 0; while (nrd() < 1 && t < 20) begin tick(1); t++; end
        frame_valid = 1'b0;
        t = 0; while (ndn() < 1 && t < 600) begin tick(1); t++; end
        noise = 1'b0; enable = 1'b0;
        tick(3);
        if (nrd() == 4 && nst() == 4 && ndn() == 1) begin
            for (int i = 0; i < 4; i++) begin
                exp  = rdd_log[12'(rdc(i) + 1)];
                last = (i < 3) ? rdc(i + 1) + 1 : dnc(0);
                bad  = 0;
                for (int c = rdc(i) + 2; c <= last; c++) if (txd_log[12'(c)] !== exp) bad++;
                n_total++; if (std(i) !== exp) $display("FAIL stable_capture%0d: got %0h want %0h", i, std(i), exp); else n_pass++;
                n_total++; if (bad != 0) $display("FAIL stable_hold%0d: got %0d changed cycles want 0", i, bad); else n_pass++;
            end
        end else begin
            n_total++; $display("FAIL stable_frame: got rd=%0d st=%0d done=%0d want 4/4/1", nrd(), nst(), ndn());
        end
    endtask

    task automatic test_rst_midframe();
        int t;
        clear_log();
        enable = 1'b1; frame_valid = 1'b1;
        t = 0; while (nrd() < 2 && t < 60) begin tick(1); t++; end
        tick(8);  // inside the second word's busy period
        rst = 1'b1;
        #1;
        n_total++; if ({frame_done, busy, rd_en, tx_start} !== 4'b0)
            $display("FAIL rst_ctrl: got %b want 0000", {frame_done, busy, rd_en, tx_start}); else n_pass++;
        n_total++; if (tx_data !== 24'h0 || rd_addr !== 2'd0)
            $display("FAIL rst_data: got %0h/%0d want 0/0", tx_data, rd_addr); else n_pass++;
        tick(2);
        n_total++; if (ndn() != 0) $display("FAIL rst_no_done: got %0d want 0", ndn()); else n_pass++;
        clear_log();
        rst = 1'b0;
        t = 0; while (nrd() < 1 && t < 20) begin tick(1); t++; end
        n_total++; if (nrd() < 1 || rda(0) !== 2'd0) $display("FAIL rst_restart_addr: got n=%0d want addr 0", nrd()); else n_pass++;
        t = 0; while (ndn() < 1 && t < 600) begin tick(1); t++; end
        frame_valid = 1'b0; enable = 1'b0;
        tick(3);
        n_total++; if (nst() != 4 || ndn() != 1) $display("FAIL rst_refill: got st=%0d done=%0d want 4/1", nst(), ndn()); else n_pass++;
    endtask

    task automatic test_timeout();
        clear_log();
        stuck = 1'b1; enable = 1'b1; frame_valid = 1'b1;
        tick(40);
        n_total++; if (error !== 1'b1) $display("FAIL to_error: got %b want 1", error); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL to_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (ndn() != 0) $display("FAIL to_no_done: got %0d want 0", ndn()); else n_pass++;
        n_total++; if (nst() != 1 || nrd() != 1) $display("FAIL to_blocked: got st=%0d rd=%0d want 1/1", nst(), nrd()); else n_pass++;
        // FETCH f, START f+2, WAIT_BUSY f+3..f+7, error visible f+8
        n_total++; if (nrd() < 1 || ner() < 1 || erc(0) - rdc(0) != 8)
            $display("FAIL to_timing: got n=%0d want error 8 cycles after rd_en", ner()); else n_pass++;
        enable = 1'b0; frame_valid = 1'b0; stuck = 1'b0;
        rst = 1'b1; tick(1); rst = 1'b0; tick(1);
        n_total++; if (error !== 1'b0) $display("FAIL to_rst_clear: got %b want 0", error); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_enable_gate();
        test_back_to_back();
        test_stable_data();
        test_rst_midframe();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/matrix_frame_sequencer.md
# matrix_frame_sequencer

Sequences one complete LED-matrix frame out of the frame buffer into the multi-channel SPI transmitter. Per word it fetches CHANNEL_NUMBER bytes from a synchronous-read buffer, presents them to the transmitter, pulses its start, and tracks its idle/busy status until the word is on the wire. After the last word it holds an inter-frame latch gap and releases the buffer back to the upstream writer. It sits between the HDMI-side frame buffer and the SPI transmitter in the output module.

## Interface
- CHANNEL_NUMBER, 3, parallel SPI data lanes (one matrix chain each)
- SPI_SIZE, 8, bits per lane per transfer (8 or 16)
- BYTES_PER_FRAME, 384, words per frame (each word = one SPI_SIZE slice per lane)
- ADDR_WIDTH, $clog2(BYTES_PER_FRAME), buffer address width
- GAP_CYCLES, 64, idle clk cycles after the last word (matrix latch time), ≥1
- BUSY_TIMEOUT, 15, max cycles waiting for transmitter to go busy, ≥1

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  frame starts allowed; sampled only in IDLE
- frame_valid  in  1  upstream buffer holds a complete frame (level)
- frame_done  out  1  one-cycle pulse: frame sent, buffer released
- busy  out  1  high in every state except IDLE
- error  out  1  sticky transmitter-timeout flag
- rd_en  out  1  buffer read strobe
- rd_addr  out  ADDR_WIDTH  buffer read address
- rd_data  in  CHANNEL_NUMBER*SPI_SIZE  read data, valid the cycle after rd_en; lane i at [i*SPI_SIZE +: SPI_SIZE]
- tx_data  out  CHANNEL_NUMBER*SPI_SIZE  word to transmitter, same lane packing
- tx_start  out  1  one-cycle start pulse to transmitter
- tx_idle  in  1  transmitter idle (high when not transmitting)

## Operation
- Reset: state IDLE; word index 0; every output 0.
- IDLE: if enable & frame_valid & !error → FETCH; index = 0.
- FETCH: rd_en=1, rd_addr=index for exactly this cycle → WAIT_DATA.
- WAIT_DATA: register rd_data into tx_data → START.
- START: tx_start=1 for exactly this cycle → WAIT_BUSY; timeout counter cleared.
- WAIT_BUSY: tx_idle==0 → WAIT_IDLE. Otherwise increment the counter; at BUSY_TIMEOUT cycles set error and go to IDLE (frame aborted, no frame_done, index reset).
- WAIT_IDLE: wait for tx_idle==1. Then, if index==BYTES_PER_FRAME-1 → GAP; else index+1 → FETCH.
- GAP: count GAP_CYCLES cycles → DONE.
- DONE: frame_done=1 for one cycle → IDLE.
- tx_data holds its value from WAIT_DATA until the next WAIT_DATA; it does not change while the transmitter is busy.
- Index arithmetic: ADDR_WIDTH bits, never exceeds BYTES_PER_FRAME-1, no wrap.
- enable and frame_valid are ignored outside IDLE; a frame in progress always completes unless it times out.
- error is cleared only by rst; while set, no frame starts.
- rst mid-frame: immediate return to IDLE with all outputs 0. No frame_done is issued.

## Timing
- Per-word overhead: FETCH, WAIT_DATA, START = 3 cycles, plus at least 1 WAIT_BUSY cycle, plus the transmitter's busy duration.
- tx_start is asserted two cycles after rd_en for the same word.
- With a transmitter that goes busy 2 cycles after start and stays busy B cycles, word period = 3 + 2 + B cycles.
- frame_done is asserted exactly GAP_CYCLES+1 cycles after the cycle in which the last word's tx_idle is seen high.
- Back-to-back frames: the earliest FETCH of the next frame is 2 cycles after frame_done (DONE → IDLE → FETCH).
- tx_idle already high or low at START has no effect. Only the sequence low-then-high after START completes a word.

## Test plan
- Basic frame (BYTES_PER_FRAME=4, GAP_CYCLES=3, transmitter model busy 18 cycles), buffer words 0x010203, 0x040506, 0x070809, 0x0A0B0C, frame_valid=1 → rd_addr sequence 0,1,2,3; four tx_start pulses; tx_data matches each word at its start; one frame_done 4 cycles after the final idle.
- Timeout: tx_idle held at 1 after start, BUSY_TIMEOUT=5 → error=1 after 5 WAIT_BUSY cycles, busy=0, no frame_done. A later frame_valid is ignored until rst.
- enable=0 with frame_valid=1 → no rd_en and no tx_start for 100 cycles. Drop enable mid-frame → the frame still completes and frame_done pulses.
- Async rst asserted during the 2nd word's WAIT_IDLE → all outputs 0 immediately. After release with frame_valid=1, the frame restarts at rd_addr=0.
- Back-to-back: frame_valid held high for 2 frames → 8 tx_start pulses and 2 frame_done pulses. The second frame's rd_en occurs 2 cycles after the first frame_done.
- Stable data: rd_data changes every cycle → tx_data stays constant from WAIT_DATA until the next FETCH+1.
